// File: rtl/branch_pc_stage_pkg.sv
// rtl/branch_pc_stage_pkg.sv - shared defaults, slot FSM encoding and target helper for the fetch PC stage
package branch_pc_stage_pkg;

  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_4180;
  localparam logic [31:0] DEF_NOP_INSTR  = 32'h0000_0000;

  // SLOT means the instruction just loaded into ID is a delay-slot instruction
  typedef enum logic {
    NORMAL = 1'b0,
    SLOT   = 1'b1
  } slot_state_e;

  // J-type target keeps the 256 MB region of the delay-slot PC
  function automatic logic [31:0] jump_target(input logic [31:0] pc4,
                                              input logic [25:0] t26);
    return {pc4[31:28], t26, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_sel.sv
// rtl/next_pc_sel.sv - combinational next-PC priority select and taken decode
import branch_pc_stage_pkg::*;

module next_pc_sel #(
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
  input  logic [31:0] pc_if,
  input  logic [31:0] pc4_id,
  input  logic [31:0] imm32_lbit,
  input  logic [25:0] target26,
  input  logic [31:0] rd1,
  input  logic [31:0] epc_in,
  input  logic        zero,
  input  logic        branch_en,
  input  logic        jump_en,
  input  logic        jr_en,
  input  logic        exc_req,
  input  logic        eret,
  input  logic        stall,
  output logic [31:0] next_pc,
  output logic        taken
);

  logic [31:0] xfer_target;

  // Transfer target; ID decodes at most one transfer kind, jr checked first
  always_comb begin
    xfer_target = pc4_id + imm32_lbit;
    if (jr_en) begin
      xfer_target = rd1;
    end else if (jump_en) begin
      xfer_target = jump_target(pc4_id, target26);
    end
  end

  assign taken = (branch_en & zero) | jump_en | jr_en;

  // Redirect priority: exception, eret, stall hold, taken transfer, sequential
  always_comb begin
    next_pc = pc_if + 32'd4;
    if (exc_req) begin
      next_pc = EXC_VECTOR;
    end else if (eret) begin
      next_pc = epc_in;
    end else if (stall) begin
      next_pc = pc_if;
    end else if (taken) begin
      next_pc = xfer_target;
    end
  end

endmodule

// File: rtl/branch_pc_stage.sv
// rtl/branch_pc_stage.sv - PC register, IF/ID register and delay-slot tracking; optional BRANCH_STATS_EN counters
import branch_pc_stage_pkg::*;

module branch_pc_stage #(
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR,
  parameter logic [31:0] NOP_INSTR  = DEF_NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        zero,
  input  logic        branch_en,
  input  logic        jump_en,
  input  logic        jr_en,
  input  logic [31:0] imm32_lbit,
  input  logic [25:0] target26,
  input  logic [31:0] rd1,
  input  logic [31:0] instr_if,
  input  logic        exc_req,
  input  logic        eret,
  input  logic [31:0] epc_in,
  output logic [31:0] pc_if,
  output logic [31:0] pc4_id,
  output logic [31:0] instr_id,
  output logic        bd_id,
  output logic        taken,
  output logic [31:0] br_cnt,
  output logic [31:0] br_taken_cnt
);

  logic [31:0] next_pc;
  logic        redirect;
  logic        ctrl_id;
  logic        bd_load;
  slot_state_e state_q;
  slot_state_e state_d;

  assign redirect = exc_req | eret;
  assign ctrl_id  = branch_en | jump_en | jr_en;

  next_pc_sel #(
    .EXC_VECTOR(EXC_VECTOR)
  ) u_sel (
    .pc_if     (pc_if),
    .pc4_id    (pc4_id),
    .imm32_lbit(imm32_lbit),
    .target26  (target26),
    .rd1       (rd1),
    .epc_in    (epc_in),
    .zero      (zero),
    .branch_en (branch_en),
    .jump_en   (jump_en),
    .jr_en     (jr_en),
    .exc_req   (exc_req),
    .eret      (eret),
    .stall     (stall),
    .next_pc   (next_pc),
    .taken     (taken)
  );

  // Slot FSM state register; flushes return to NORMAL, stalls freeze it
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= NORMAL;
    end else if (redirect) begin
      state_q <= NORMAL;
    end else if (!stall) begin
      state_q <= state_d;
    end
  end

  // Slot FSM next state; a transfer leaving NORMAL marks the incoming instr as a slot
  always_comb begin
    state_d = state_q;
    bd_load = 1'b0;
    case (state_q)
      NORMAL: begin
        if (ctrl_id) begin
          state_d = SLOT;
          bd_load = 1'b1;
        end
      end
      SLOT: begin
        state_d = NORMAL;
      end
      default: begin
        state_d = NORMAL;
      end
    endcase
  end

  // PC and IF/ID registers; flush overrides stall, stall holds everything
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_if    <= RESET_PC;
      instr_id <= NOP_INSTR;
      pc4_id   <= RESET_PC + 32'd4;
      bd_id    <= 1'b0;
    end else if (redirect) begin
      pc_if    <= next_pc;
      instr_id <= NOP_INSTR;
      pc4_id   <= next_pc + 32'd4;
      bd_id    <= 1'b0;
    end else if (!stall) begin
      pc_if    <= next_pc;
      instr_id <= instr_if;
      pc4_id   <= pc_if + 32'd4;
      bd_id    <= bd_load;
    end
  end

`ifdef BRANCH_STATS_EN
  logic [31:0] br_cnt_q;
  logic [31:0] br_taken_cnt_q;

  // Count conditional branches that actually resolve (not stalled, not flushed)
  always_ff @(posedge clk) begin
    if (reset) begin
      br_cnt_q       <= 32'h0;
      br_taken_cnt_q <= 32'h0;
    end else if (branch_en && !stall && !redirect) begin
      br_cnt_q <= br_cnt_q + 32'd1;
      if (zero) begin
        br_taken_cnt_q <= br_taken_cnt_q + 32'd1;
      end
    end
  end

  assign br_cnt       = br_cnt_q;
  assign br_taken_cnt = br_taken_cnt_q;
`else
  assign br_cnt       = 32'h0;
  assign br_taken_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_branch_pc_stage.sv
// tb/tb_branch_pc_stage.sv - vector table plus randomized model check of branch_pc_stage
module tb_branch_pc_stage;

`ifdef BRANCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, stall, zero, branch_en, jump_en, jr_en, exc_req, eret;
  logic [31:0] imm32_lbit, rd1, instr_if, epc_in;
  logic [25:0] target26;
  logic [31:0] pc_if, pc4_id, instr_id, br_cnt, br_taken_cnt;
  logic        bd_id, taken;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  branch_pc_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .zero(zero),
    .branch_en(branch_en), .jump_en(jump_en), .jr_en(jr_en),
    .imm32_lbit(imm32_lbit), .target26(target26), .rd1(rd1),
    .instr_if(instr_if), .exc_req(exc_req), .eret(eret), .epc_in(epc_in),
    .pc_if(pc_if), .pc4_id(pc4_id), .instr_id(instr_id), .bd_id(bd_id),
    .taken(taken), .br_cnt(br_cnt), .br_taken_cnt(br_taken_cnt)
  );

  typedef struct {
    logic        rst, stl, z, be, je, jre, exc, ert;
    logic [31:0] imm;
    logic [25:0] t26;
    logic [31:0] r1, epc, ins;
    logic        e_taken;
    logic [31:0] e_pc, e_pc4, e_ins;
    logic        e_bd;
    logic [31:0] e_br, e_brt;
  } vec_t;

  vec_t vecs[21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, stl, z, be, je, jre, exc, ert,
                       input logic [31:0] imm, input logic [25:0] t26,
                       input logic [31:0] r1, epc, ins);
    reset = rst; stall = stl; zero = z; branch_en = be; jump_en = je; jr_en = jre;
    exc_req = exc; eret = ert; imm32_lbit = imm; target26 = t26; rd1 = r1;
    epc_in = epc; instr_if = ins;
  endtask

  // reference model state: architectural view of PC, ID slot and counters
  logic [31:0] m_pc, m_pc4, m_ins, m_br, m_brt;
  logic        m_bd;

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    //          rst stl z be je jr ex er imm           t26         rd1          epc          instr        tk pc           pc4          instr        bd br brt
    vecs[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 32'h0,        26'h0,      32'h0,       32'h0,       32'h0,       0, 32'h3000, 32'h3004, 32'h0,        0, 0, 0};
    vecs[1]  = '{0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        26'h0,      32'h0,       32'h0,       32'h11113000,0, 32'h3004, 32'h3004, 32'h11113000, 0, 0, 0};
    vecs[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        26'h0,      32'h0,       32'h0,       32'h11113004,0, 32'h3008, 32'h3008, 32'h11113004, 0, 0, 0};
    vecs[3]  = '{0, 0, 1, 1, 0, 0, 0, 0, 32'hFFFFFFF8, 26'h0,      32'h0,       32'h0,       32'h11113008,1, 32'h3000, 32'h300C, 32'h11113008, 1, 1, 1};
    vecs[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        26'h0,      32'h0,       32'h0,       32'h11113000,0, 32'h3004, 32'h3004, 32'h11113000, 0, 1, 1};
    vecs[5]  = '{0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        26'h0,      32'h0,       32'h0,       32'h11113004,0, 32'h3008, 32'h3008, 32'h11113004, 0, 1, 1};
    vecs[6]  = '{0, 0, 0, 1, 0, 0, 0, 0, 32'hFFFFFFF8, 26'h0,      32'h0,       32'h0,       32'h11113008,0, 32'h300C, 32'h300C, 32'h11113008, 1, 2, 1};
    vecs[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        26'h0,      32'h0,       32'h0,       32'h1111300C,0, 32'h3010, 32'h3010, 32'h1111300C, 0, 2, 1};
    vecs[8]  = '{0, 1, 0, 0, 0, 1, 0, 0, 32'h0,        26'h0,      32'h3400,    32'h0,       32'h11113010,1, 32'h3010, 32'h3010, 32'h1111300C, 0, 2, 1};
    vecs[9]  = '{0, 1, 0, 0, 0, 1, 0, 0, 32'h0,        26'h0,      32'h3400,    32'h0,       32'h11113010,1, 32'h3010, 32'h3010, 32'h1111300C, 0, 2, 1};
    vecs[10] = '{0, 0, 0, 0, 0, 1, 0, 0, 32'h0,        26'h0,      32'h3400,    32'h0,       32'h11113010,1, 32'h3400, 32'h3014, 32'h11113010, 1, 2, 1};
    vecs[11] = '{0, 1, 0, 0, 0, 0, 1, 1, 32'h0,        26'h0,      32'h0,       32'h5000,    32'h11113400,0, 32'h4180, 32'h4184, 32'h0,        0, 2, 1};
    vecs[12] = '{0, 0, 0, 0, 1, 0, 0, 0, 32'h0,        26'h0000C40,32'h0,       32'h0,       32'h11114180,1, 32'h3100, 32'h4184, 32'h11114180, 1, 2, 1};
    vecs[13] = '{0, 0, 0, 0, 0, 0, 0, 1, 32'h0,        26'h0,      32'h0,       32'h2000,    32'h11113100,0, 32'h2000, 32'h2004, 32'h0,        0, 2, 1};
    vecs[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        26'h0,      32'h0,       32'h0,       32'h11112000,0, 32'h2004, 32'h2004, 32'h11112000, 0, 2, 1};
    vecs[15] = '{0, 0, 1, 1, 0, 0, 0, 0, 32'h10,       26'h0,      32'h0,       32'h0,       32'h11112004,1, 32'h2014, 32'h2008, 32'h11112004, 1, 3, 2};
    vecs[16] = '{1, 0, 1, 1, 0, 0, 0, 0, 32'h10,       26'h0,      32'h0,       32'h0,       32'h11112014,1, 32'h3000, 32'h3004, 32'h0,        0, 0, 0};
    vecs[17] = '{0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        26'h0,      32'h0,       32'h0,       32'h11113000,0, 32'h3004, 32'h3004, 32'h11113000, 0, 0, 0};
    vecs[18] = '{0, 0, 0, 0, 1, 0, 0, 0, 32'h0,        26'h0000C80,32'h0,       32'h0,       32'h22223004,1, 32'h3200, 32'h3008, 32'h22223004, 1, 0, 0};
    vecs[19] = '{0, 0, 1, 1, 0, 0, 0, 0, 32'h100,      26'h0,      32'h0,       32'h0,       32'h22223200,1, 32'h3108, 32'h3204, 32'h22223200, 0, 1, 1};
    vecs[20] = '{0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        26'h0,      32'h0,       32'h0,       32'h22223108,0, 32'h310C, 32'h310C, 32'h22223108, 0, 1, 1};

    for (int i = 0; i < 21; i++) begin
      drive(vecs[i].rst, vecs[i].stl, vecs[i].z, vecs[i].be, vecs[i].je, vecs[i].jre,
            vecs[i].exc, vecs[i].ert, vecs[i].imm, vecs[i].t26, vecs[i].r1,
            vecs[i].epc, vecs[i].ins);
      #1;
      chk($sformatf("vec%0d taken", i), {31'h0, taken}, {31'h0, vecs[i].e_taken});
      @(posedge clk); #1;
      chk($sformatf("vec%0d pc_if", i), pc_if, vecs[i].e_pc);
      chk($sformatf("vec%0d pc4_id", i), pc4_id, vecs[i].e_pc4);
      chk($sformatf("vec%0d instr_id", i), instr_id, vecs[i].e_ins);
      chk($sformatf("vec%0d bd_id", i), {31'h0, bd_id}, {31'h0, vecs[i].e_bd});
      chk($sformatf("vec%0d br_cnt", i), br_cnt, STATS ? vecs[i].e_br : 32'h0);
      chk($sformatf("vec%0d br_taken_cnt", i), br_taken_cnt, STATS ? vecs[i].e_brt : 32'h0);
    end

    // randomized run against the reference model
    for (int i = 0; i < 600; i++) begin
      logic        r_rst, r_stl, r_z, r_be, r_je, r_jre, r_exc, r_ert, e_tk, is_ctrl;
      logic [31:0] r_imm, r_r1, r_epc, r_ins, tgt, npc;
      logic [25:0] r_t26;
      int          kind;
      kind  = $urandom_range(0, 5);
      r_rst = (i == 0) || ($urandom_range(0, 49) == 0);
      r_stl = ($urandom_range(0, 3) == 0);
      r_z   = $urandom_range(0, 1);
      r_be  = (kind == 0);
      r_je  = (kind == 1);
      r_jre = (kind == 2);
      r_exc = ($urandom_range(0, 19) == 0);
      r_ert = ($urandom_range(0, 19) == 0);
      r_imm = $urandom; r_r1 = $urandom; r_epc = $urandom; r_ins = $urandom;
      r_t26 = 26'($urandom);
      drive(r_rst, r_stl, r_z, r_be, r_je, r_jre, r_exc, r_ert, r_imm, r_t26, r_r1, r_epc, r_ins);

      is_ctrl = r_be | r_je | r_jre;
      e_tk    = (r_be && r_z) || r_je || r_jre;
      if (r_jre)     tgt = r_r1;
      else if (r_je) tgt = {m_pc4[31:28], r_t26, 2'b00};
      else           tgt = m_pc4 + r_imm;
      #1;
      if (i != 0) chk("rand taken", {31'h0, taken}, {31'h0, e_tk});

      if (r_rst) begin
        m_pc = 32'h3000; m_pc4 = 32'h3004; m_ins = 32'h0; m_bd = 1'b0; m_br = 0; m_brt = 0;
      end else if (r_exc || r_ert) begin
        npc = r_exc ? 32'h4180 : r_epc;
        m_pc = npc; m_pc4 = npc + 32'd4; m_ins = 32'h0; m_bd = 1'b0;
      end else if (!r_stl) begin
        if (r_be) begin
          m_br++;
          if (r_z) m_brt++;
        end
        // an instruction is a delay slot iff the one ahead of it was a transfer outside a slot
        m_bd  = is_ctrl && !m_bd;
        m_ins = r_ins;
        m_pc4 = m_pc + 32'd4;
        m_pc  = e_tk ? tgt : m_pc + 32'd4;
      end

      @(posedge clk); #1;
      chk("rand pc_if", pc_if, m_pc);
      chk("rand pc4_id", pc4_id, m_pc4);
      chk("rand instr_id", instr_id, m_ins);
      chk("rand bd_id", {31'h0, bd_id}, {31'h0, m_bd});
      chk("rand br_cnt", br_cnt, STATS ? m_br : 32'h0);
      chk("rand br_taken_cnt", br_taken_cnt, STATS ? m_brt : 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
